// File: rtl/tile_collision_probe_pkg.sv
// Shared types and constants for the tile collision probe: FSM states,
// side-bit indices of the {up, down, left, right} vector, probe count.
package tile_collision_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int UP     = 3;
  localparam int DOWN   = 2;
  localparam int LEFT   = 1;
  localparam int RIGHT  = 0;
  localparam int NPROBE = 8;

  // Probes come in pairs per side: k[2:1] selects up, down, left, right.
  function automatic logic [1:0] side_bit(input logic [2:0] k);
    logic [1:0] idx;
    case (k[2:1])
      2'd0:    idx = 2'(UP);
      2'd1:    idx = 2'(DOWN);
      2'd2:    idx = 2'(LEFT);
      default: idx = 2'(RIGHT);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/tile_collision_probe_if.sv
// Tile-map lookup handshake: the probe (master) requests a pixel coordinate,
// the tile map (slave) answers with a valid strobe and a solid flag.
interface tile_collision_probe_if #(
  parameter int POS_W = 10
);
  logic             probe_valid;
  logic [POS_W-1:0] probe_x;
  logic [POS_W-1:0] probe_y;
  logic             tile_valid;
  logic             tile_solid;

  modport master (
    output probe_valid, probe_x, probe_y,
    input  tile_valid, tile_solid
  );

  modport slave (
    input  probe_valid, probe_x, probe_y,
    output tile_valid, tile_solid
  );
endinterface

// File: rtl/tile_collision_probe_tick_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for sim_tick;
// a 0->1 transition on tick_i yields a one-cycle tick_o three cycles later.
module tile_collision_probe_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  output logic tick_o
);
  // sync_q[0..1] are the synchronizer stages, sync_q[2] holds the previous level.
  logic [2:0] sync_q;
  logic       pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], tick_i};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign tick_o = pulse_q;
endmodule

// File: rtl/tile_collision_probe.sv
// Per-tick collision sampler: walks 8 edge probes of one sprite through the
// tile lookup handshake. Define TILE_PROBE_TICK_SYNC_EN for an asynchronous sim_tick_i.
module tile_collision_probe
  import tile_collision_probe_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sim_tick_i,
  input  logic [2*POS_W-1:0]     sprite_pos_i,
  tile_collision_probe_if.master lk,
  output logic [3:0]             col_o,
  output logic                   col_valid_o,
  output logic                   busy_o,
  output logic                   tick_drop_o
);
  typedef logic [POS_W-1:0] pos_t;
  typedef logic [POS_W:0]   ext_t;

  localparam pos_t SPR_W_P    = pos_t'(SPR_W);
  localparam pos_t SPR_W_M1_P = pos_t'(SPR_W - 1);
  localparam pos_t SPR_H_P    = pos_t'(SPR_H);
  localparam pos_t SPR_H_M1_P = pos_t'(SPR_H - 1);
  localparam pos_t ONE_P      = pos_t'(1);
  localparam ext_t SPR_W_E    = ext_t'(SPR_W);
  localparam ext_t SPR_H_E    = ext_t'(SPR_H);
  localparam ext_t SCR_W_E    = ext_t'(SCREEN_W);
  localparam ext_t SCR_H_E    = ext_t'(SCREEN_H);

  state_e     state_q, state_d;
  logic [2:0] k_q, k_d;
  pos_t       px_q, px_d, py_q, py_d;
  pos_t       prx_q, prx_d, pry_q, pry_d;
  logic       probe_valid_q, probe_valid_d;
  logic [3:0] acc_q, acc_d, col_q, col_d;

  logic       tick_evt;
  pos_t       pr_x, pr_y;
  logic       pr_oob;
  logic [3:0] hit_mask;
  logic       last, step;

`ifdef TILE_PROBE_TICK_SYNC_EN
  tile_collision_probe_tick_sync u_tick_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (sim_tick_i),
    .tick_o (tick_evt)
  );
`else
  assign tick_evt = sim_tick_i;
`endif

  // Probe k address and bounds; bounds sums are one bit wider than a coordinate.
  always_comb begin
    pr_x   = px_q;
    pr_y   = py_q;
    pr_oob = 1'b0;
    case (k_q[2:1])
      2'd0: begin
        pr_x   = k_q[0] ? px_q + SPR_W_M1_P : px_q;
        pr_y   = py_q - ONE_P;
        pr_oob = (py_q == '0);
      end
      2'd1: begin
        pr_x   = k_q[0] ? px_q + SPR_W_M1_P : px_q;
        pr_y   = py_q + SPR_H_P;
        pr_oob = (({1'b0, py_q} + SPR_H_E) >= SCR_H_E);
      end
      2'd2: begin
        pr_x   = px_q - ONE_P;
        pr_y   = k_q[0] ? py_q + SPR_H_M1_P : py_q;
        pr_oob = (px_q == '0);
      end
      default: begin
        pr_x   = px_q + SPR_W_P;
        pr_y   = k_q[0] ? py_q + SPR_H_M1_P : py_q;
        pr_oob = (({1'b0, px_q} + SPR_W_E) >= SCR_W_E);
      end
    endcase
  end

  assign hit_mask = 4'b0001 << side_bit(k_q);
  assign last     = (k_q == 3'(NPROBE - 1));

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    px_d          = px_q;
    py_d          = py_q;
    prx_d         = prx_q;
    pry_d         = pry_q;
    probe_valid_d = probe_valid_q;
    acc_d         = acc_q;
    col_d         = col_q;
    step          = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick_evt) begin
          state_d = ISSUE;
          px_d    = sprite_pos_i[2*POS_W-1 -: POS_W];
          py_d    = sprite_pos_i[POS_W-1:0];
          acc_d   = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (pr_oob) begin
          acc_d = acc_q | hit_mask;
          step  = 1'b1;
        end else begin
          probe_valid_d = 1'b1;
          prx_d         = pr_x;
          pry_d         = pr_y;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (lk.tile_valid) begin
          if (lk.tile_solid) acc_d = acc_q | hit_mask;
          probe_valid_d = 1'b0;
          step          = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // col is loaded on entry to DONE so it is already valid with the col_valid pulse.
    if (step) begin
      if (last) begin
        state_d = DONE;
        col_d   = acc_d;
      end else begin
        state_d = ISSUE;
        k_d     = k_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= '0;
      px_q          <= '0;
      py_q          <= '0;
      prx_q         <= '0;
      pry_q         <= '0;
      probe_valid_q <= 1'b0;
      acc_q         <= '0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      px_q          <= px_d;
      py_q          <= py_d;
      prx_q         <= prx_d;
      pry_q         <= pry_d;
      probe_valid_q <= probe_valid_d;
      acc_q         <= acc_d;
      col_q         <= col_d;
    end
  end

  assign lk.probe_valid = probe_valid_q;
  assign lk.probe_x     = prx_q;
  assign lk.probe_y     = pry_q;
  assign col_o          = col_q;
  assign col_valid_o    = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign tick_drop_o    = tick_evt && (state_q != IDLE);
endmodule
